// File: rtl/clk_monitor.sv
// Measures high/low phases and period of an asynchronous mon_clk in clk cycles and flags short, long and stuck phases.
// Optional duty-cycle check is built only when CLK_MON_DUTY_CHECK_EN is defined.
module clk_monitor #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned HALF_MIN = 4,
    parameter int unsigned HALF_MAX = 8,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned DUTY_TOL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             err_short,
    output logic             err_long,
    output logic             err_stuck,
    output logic             err_duty
);

    if (TIMEOUT <= HALF_MAX || (TIMEOUT >> CNT_W) != 0 || (DUTY_TOL >> CNT_W) != 0) begin : g_cfg_error
        $error("clk_monitor: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SYNC, MEAS_HI, MEAS_LO} state_t;

    state_t           state, state_nxt;
    logic             s_meta, s, s_d;
    logic [2:0]       fill;
    logic             rise, fall, mon_edge;
    logic [CNT_W-1:0] cnt;
    logic             stuck;
    logic             latch_hi, latch_lo, set_stuck;
    logic             phase_short, phase_long;
    logic             set_short, set_long;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
            fill   <= '0;
        end else begin
            s_meta <= mon_clk;
            s      <= s_meta;
            s_d    <= s;
            fill   <= {fill[1:0], 1'b1};
        end
    end

    // Edges are ignored until s_d holds a real sample, so a high mon_clk at reset release is not taken as a rise.
    assign rise     = fill[2] & s & ~s_d;
    assign fall     = fill[2] & ~s & s_d;
    assign mon_edge = rise | fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (mon_edge) begin
            cnt <= CNT_W'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A coincident edge wins over the timeout so a restarting clock is picked up straight away in SYNC.
    assign stuck = (state != IDLE) && !mon_edge && (cnt >= CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_hi  = 1'b0;
        latch_lo  = 1'b0;
        set_stuck = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else if (stuck) begin
            set_stuck = 1'b1;
            state_nxt = SYNC;
        end else begin
            case (state)
                IDLE:    state_nxt = SYNC;
                SYNC:    if (rise) state_nxt = MEAS_HI;
                MEAS_HI: if (fall) begin
                    latch_hi  = 1'b1;
                    state_nxt = MEAS_LO;
                end
                MEAS_LO: if (rise) begin
                    latch_lo  = 1'b1;
                    state_nxt = MEAS_HI;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign phase_short = cnt < CNT_W'(HALF_MIN);
    assign phase_long  = cnt > CNT_W'(HALF_MAX);
    assign set_short   = (latch_hi | latch_lo) & phase_short;
    assign set_long    = (latch_hi | latch_lo) & phase_long;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_time  <= '0;
            low_time   <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_stuck  <= 1'b0;
        end else begin
            meas_valid <= latch_lo;
            if (latch_hi) high_time <= cnt;
            if (latch_lo) begin
                low_time <= cnt;
                period   <= {1'b0, high_time} + {1'b0, cnt};
            end
            err_short <= set_short | (err_short & ~clr);
            err_long  <= set_long  | (err_long  & ~clr);
            err_stuck <= set_stuck | (err_stuck & ~clr);
        end
    end

`ifdef CLK_MON_DUTY_CHECK_EN
    logic [CNT_W-1:0] duty_diff;
    logic             set_duty;

    assign duty_diff = (high_time >= cnt) ? (high_time - cnt) : (cnt - high_time);
    assign set_duty  = latch_lo & (duty_diff > CNT_W'(DUTY_TOL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_duty <= 1'b0;
        else        err_duty <= set_duty | (err_duty & ~clr);
    end
`else
    assign err_duty = 1'b0;
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// Scoreboard bench for clk_monitor: each driven mon_clk period queues its expected measurement, checked on meas_valid.
`timescale 1ns/1ps
module tb_clk_monitor;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n, en, clr, mon_clk;
    logic [CNT_W-1:0] high_time, low_time;
    logic [CNT_W:0]   period;
    logic             meas_valid, err_short, err_long, err_stuck, err_duty;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { int h; int l; } exp_t;
    exp_t sb[$];

    clk_monitor #(
        .CNT_W   (CNT_W),
        .HALF_MIN(4),
        .HALF_MAX(8),
        .TIMEOUT (64),
        .DUTY_TOL(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .mon_clk   (mon_clk),
        .high_time (high_time),
        .low_time  (low_time),
        .period    (period),
        .meas_valid(meas_valid),
        .err_short (err_short),
        .err_long  (err_long),
        .err_stuck (err_stuck),
        .err_duty  (err_duty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (meas_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_meas_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("high_time", high_time, e.h);
                check("low_time", low_time, e.l);
                check("period", period, e.h + e.l);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_period(input int h, input int l, input bit push);
        if (push) sb.push_back('{h, l});
        mon_clk = 1'b1;
        cyc(h);
        mon_clk = 1'b0;
        cyc(l);
    endtask

    task automatic start_run();
        en = 1'b1;
        cyc(4);
    endtask

    // final rise reports the last queued period, then the monitor is disabled
    task automatic close_run();
        mon_clk = 1'b1;
        cyc(5);
        en      = 1'b0;
        mon_clk = 1'b0;
        cyc(4);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(1);
    endtask

    initial begin
        int n;
        bit duty_exp;
`ifdef CLK_MON_DUTY_CHECK_EN
        duty_exp = 1'b1;
`else
        duty_exp = 1'b0;
`endif
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; mon_clk = 1'b0;
        cyc(3);
        check("rst_high_time", high_time, 0);
        check("rst_period", period, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_errs", {err_short, err_long, err_stuck, err_duty}, 0);
        rst_n = 1'b1;
        cyc(2);

        // nominal 5/5
        start_run();
        repeat (6) drive_period(5, 5, 1'b1);
        close_run();
        check("nom_errs", {err_short, err_long, err_stuck, err_duty}, 0);

        // 3/3 too short
        start_run();
        repeat (4) drive_period(3, 3, 1'b1);
        close_run();
        check("short_err_short", err_short, 1);
        check("short_err_long", err_long, 0);
        check("short_period", period, 6);
        clr_pulse();
        check("short_cleared", err_short, 0);

        // 9/9 too long, then clear
        start_run();
        repeat (3) drive_period(9, 9, 1'b1);
        close_run();
        check("long_err_long", err_long, 1);
        check("long_err_short", err_short, 0);
        check("long_period", period, 18);
        clr_pulse();
        check("long_cleared", err_long, 0);

        // clr in the same cycle the 9-cycle high phase is latched
        start_run();
        sb.push_back('{9, 9});
        mon_clk = 1'b1;
        cyc(9);
        mon_clk = 1'b0;
        cyc(2);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("long_set_wins", err_long, 1);
        cyc(6);
        close_run();
        clr_pulse();

        // stuck low for 100 cycles mid-run
        start_run();
        repeat (2) drive_period(5, 5, 1'b1);
        mon_clk = 1'b1;
        cyc(5);
        mon_clk = 1'b0;
        n = 0;
        while (!err_stuck && n < 100) begin
            cyc(1);
            n++;
        end
        check("stuck_latency", n, 67);
        if (n < 100) cyc(100 - n);
        check("stuck_flag", err_stuck, 1);
        repeat (3) drive_period(5, 5, 1'b1);
        close_run();
        check("stuck_sticky", err_stuck, 1);
        check("stuck_no_long", err_long, 0);
        clr_pulse();
        check("stuck_cleared", err_stuck, 0);

        // 4 high / 8 low duty violation
        start_run();
        repeat (3) drive_period(4, 8, 1'b1);
        close_run();
        check("duty_err_short", err_short, 0);
        check("duty_err_long", err_long, 0);
        check("duty_err_duty", err_duty, duty_exp);
        clr_pulse();
        check("duty_cleared", err_duty, 0);

        // reset asserted mid high phase, released with en held
        start_run();
        drive_period(3, 3, 1'b1);
        drive_period(5, 5, 1'b0);
        mon_clk = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        #1;
        check("midrst_high_time", high_time, 0);
        check("midrst_low_time", low_time, 0);
        check("midrst_period", period, 0);
        check("midrst_errs", {meas_valid, err_short, err_long, err_stuck, err_duty}, 0);
        check("midrst_sb", sb.size(), 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        mon_clk = 1'b0;
        cyc(5);
        drive_period(5, 5, 1'b1);
        drive_period(3, 3, 1'b1);
        mon_clk = 1'b1;
        cyc(5);
        check("postrst_sb", sb.size(), 0);
        check("postrst_err_short", err_short, 1);

        // disabled: toggling continues, nothing reported, errors hold
        en = 1'b0;
        mon_clk = 1'b0;
        cyc(2);
        repeat (3) drive_period(5, 5, 1'b0);
        check("dis_err_short", err_short, 1);
        check("dis_period", period, 6);
        check("dis_sb", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
